// File: rtl/bram_access_arbiter.sv
// Shares one BRAM port between the host path (h) and the JPEG engine path (e):
// engine-priority arbitration with bounded host starvation, registered BRAM drive, tagged read return.
module bram_access_arbiter #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 2,
    parameter int MAX_GRANT  = 4
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      h_req,
    input  logic                      h_we,
    input  logic [ADDR_WIDTH-1:0]     h_addr,
    input  logic [DATA_WIDTH-1:0]     h_wdata,
    input  logic [DATA_WIDTH/8-1:0]   h_wstrb,
    output logic                      h_ack,
    output logic                      h_rvalid,
    output logic [DATA_WIDTH-1:0]     h_rdata,
    input  logic                      e_req,
    input  logic                      e_we,
    input  logic [ADDR_WIDTH-1:0]     e_addr,
    input  logic [DATA_WIDTH-1:0]     e_wdata,
    input  logic [DATA_WIDTH/8-1:0]   e_wstrb,
    output logic                      e_ack,
    output logic                      e_rvalid,
    output logic [DATA_WIDTH-1:0]     e_rdata,
    output logic                      bram_en,
    output logic [DATA_WIDTH/8-1:0]   bram_we,
    output logic [ADDR_WIDTH-1:0]     bram_addr,
    output logic [DATA_WIDTH-1:0]     bram_wdata,
    input  logic [DATA_WIDTH-1:0]     bram_rdata,
    output logic                      busy
);
    localparam logic [3:0] STREAK_MAX = 4'(MAX_GRANT);

    logic [3:0]            streak;
    logic                  h_win;
    logic                  e_win;
    logic [RD_LATENCY-1:0] tag_v;
    logic [RD_LATENCY-1:0] tag_h;

    // Host wins when alone or once the engine has used up its streak of grants over a waiting host.
    always_comb begin
        h_win = h_req && (!e_req || streak == STREAK_MAX);
        e_win = e_req && !h_win;
    end

    assign h_ack   = h_win;
    assign e_ack   = e_win;
    assign busy    = |tag_v;
    assign h_rdata = h_rvalid ? bram_rdata : '0;
    assign e_rdata = e_rvalid ? bram_rdata : '0;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            streak <= '0;
        end else if (!h_req || h_win) begin
            streak <= '0;
        end else if (e_win && streak != STREAK_MAX) begin
            streak <= streak + 4'd1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            bram_en    <= 1'b0;
            bram_we    <= '0;
            bram_addr  <= '0;
            bram_wdata <= '0;
        end else begin
            bram_en <= h_win || e_win;
            if (h_win) begin
                bram_we    <= h_we ? h_wstrb : '0;
                bram_addr  <= h_addr;
                bram_wdata <= h_wdata;
            end else if (e_win) begin
                bram_we    <= e_we ? e_wstrb : '0;
                bram_addr  <= e_addr;
                bram_wdata <= e_wdata;
            end else begin
                bram_we <= '0;
            end
        end
    end

    // Tag stage 0 lines up with bram_en; the final register aligns rvalid with bram_rdata.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            tag_v    <= '0;
            tag_h    <= '0;
            h_rvalid <= 1'b0;
            e_rvalid <= 1'b0;
        end else begin
            tag_v[0] <= (h_win && !h_we) || (e_win && !e_we);
            tag_h[0] <= h_win;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_h[i] <= tag_h[i-1];
            end
            h_rvalid <= tag_v[RD_LATENCY-1] && tag_h[RD_LATENCY-1];
            e_rvalid <= tag_v[RD_LATENCY-1] && !tag_h[RD_LATENCY-1];
        end
    end
endmodule

// File: tb/tb_bram_access_arbiter.sv
// Bench for bram_access_arbiter: BRAM model, reference memory with read scoreboard, scenario tasks.
module tb_bram_access_arbiter;
    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int RDL  = 2;
    localparam int MAXG = 4;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          h_req = 1'b0, h_we = 1'b0;
    logic [AW-1:0] h_addr = '0;
    logic [DW-1:0] h_wdata = '0;
    logic [SW-1:0] h_wstrb = '0;
    logic          h_ack, h_rvalid;
    logic [DW-1:0] h_rdata;
    logic          e_req = 1'b0, e_we = 1'b0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0;
    logic [SW-1:0] e_wstrb = '0;
    logic          e_ack, e_rvalid;
    logic [DW-1:0] e_rdata;
    logic          bram_en;
    logic [SW-1:0] bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [DW-1:0] bram_rdata;
    logic          busy;

    always #5 ACLK = ~ACLK;

    bram_access_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RDL), .MAX_GRANT(MAXG)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_wstrb(h_wstrb),
        .h_ack(h_ack), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata), .e_wstrb(e_wstrb),
        .e_ack(e_ack), .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge ACLK) cyc <= cyc + 1;

    // BRAM model: data appears RDL cycles after the edge that samples bram_en
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rd_pipe [RDL];
    always @(posedge ACLK) begin
        if (bram_en) begin
            for (int b = 0; b < SW; b++)
                if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
            rd_pipe[0] <= mem[bram_addr];
        end
        for (int i = 1; i < RDL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rdata = rd_pipe[RDL-1];

    // Reference memory and scoreboard, updated at the ack cycle
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic [DW-1:0] exp_q[$];
    bit            exp_own_q[$];
    int            exp_cyc_q[$];
    bit            p_en = 1'b0;
    logic [SW-1:0] p_we = '0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_wdata = '0;
    bit            log_on = 1'b0;
    bit            grant_log[$];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i]     = DW'(i + 1);
            ref_mem[i] = DW'(i + 1);
        end
    end

    task automatic model_grant(input bit host, input bit we, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input logic [SW-1:0] s);
        p_we    = we ? s : '0;
        p_addr  = a;
        p_wdata = d;
        if (we) begin
            for (int b = 0; b < SW; b++)
                if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
        end else begin
            exp_q.push_back(ref_mem[a]);
            exp_own_q.push_back(host);
            exp_cyc_q.push_back(cyc);
        end
        if (log_on) grant_log.push_back(host);
    endtask

    always @(negedge ACLK) begin
        if (ARESET) begin
            exp_q.delete();
            exp_own_q.delete();
            exp_cyc_q.delete();
            p_en = 1'b0;
        end else begin
            checks++;
            if (bram_en !== p_en) begin
                errors++;
                $display("FAIL bram_en cyc=%0d got=%b exp=%b", cyc, bram_en, p_en);
            end
            if (p_en) begin
                checks++;
                if ({bram_we, bram_addr, bram_wdata} !== {p_we, p_addr, p_wdata}) begin
                    errors++;
                    $display("FAIL bram_drive cyc=%0d got we=%h a=%h d=%h exp we=%h a=%h d=%h",
                             cyc, bram_we, bram_addr, bram_wdata, p_we, p_addr, p_wdata);
                end
            end
            if (exp_cyc_q.size() > 0 && cyc > exp_cyc_q[0] + RDL + 1) begin
                checks++;
                errors++;
                $display("FAIL rvalid_missing cyc=%0d ack_cyc=%0d got=none exp=%h",
                         cyc, exp_cyc_q[0], exp_q[0]);
                void'(exp_q.pop_front());
                void'(exp_own_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (h_rvalid || e_rvalid) begin
                checks++;
                if (h_rvalid && e_rvalid) begin
                    errors++;
                    $display("FAIL rvalid_both cyc=%0d got=11 exp=one-hot", cyc);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected cyc=%0d got h=%b e=%b exp=none", cyc, h_rvalid, e_rvalid);
                end else begin
                    logic [DW-1:0] d;
                    bit            o;
                    int            c;
                    d = exp_q.pop_front();
                    o = exp_own_q.pop_front();
                    c = exp_cyc_q.pop_front();
                    if (o != h_rvalid || (h_rvalid ? h_rdata : e_rdata) !== d || cyc != c + RDL + 1) begin
                        errors++;
                        $display("FAIL rvalid_data cyc=%0d got own_h=%b data=%h exp own_h=%b data=%h at_cyc=%0d",
                                 cyc, h_rvalid, h_rvalid ? h_rdata : e_rdata, o, d, c + RDL + 1);
                    end
                end
            end
            checks++;
            if (h_ack && e_ack) begin
                errors++;
                $display("FAIL double_ack cyc=%0d got=11 exp=at most one", cyc);
            end
            p_en = h_ack || e_ack;
            if (h_ack)      model_grant(1'b1, h_we, h_addr, h_wdata, h_wstrb);
            else if (e_ack) model_grant(1'b0, e_we, e_addr, e_wdata, e_wstrb);
        end
    end

    // Driver tasks: entered just after a rising edge, return just after the edge following ack
    task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, output int ack_cyc);
        int n = 0;
        h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d; h_wstrb = s;
        @(negedge ACLK);
        while (!h_ack && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (!h_ack) begin
            errors++;
            $display("FAIL host_ack_timeout addr=%h got=no ack exp=ack within 100 cycles", a);
        end
        ack_cyc = cyc;
        @(posedge ACLK);
        #1;
        h_req = 1'b0;
    endtask

    task automatic eng_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, output int ack_cyc);
        int n = 0;
        e_req = 1'b1; e_we = we; e_addr = a; e_wdata = d; e_wstrb = s;
        @(negedge ACLK);
        while (!e_ack && n < 100) begin
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (!e_ack) begin
            errors++;
            $display("FAIL eng_ack_timeout addr=%h got=no ack exp=ack within 100 cycles", a);
        end
        ack_cyc = cyc;
        @(posedge ACLK);
        #1;
        e_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    task automatic wait_h_rvalid(input string name, input int ack_c, input logic [DW-1:0] exp_d);
        int n = 0;
        @(negedge ACLK);
        while (!h_rvalid && n < 10) begin
            checks++;
            if (e_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL %s_e_rvalid cyc=%0d got=%b exp=0", name, cyc, e_rvalid);
            end
            @(negedge ACLK);
            n++;
        end
        checks++;
        if (!h_rvalid || cyc != ack_c + RDL + 1 || h_rdata !== exp_d) begin
            errors++;
            $display("FAIL %s cyc=%0d got rvalid=%b data=%h exp rvalid at cyc %0d data=%h",
                     name, cyc, h_rvalid, h_rdata, ack_c + RDL + 1, exp_d);
        end
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        #1;
        checks++;
        if ({h_ack, e_ack, h_rvalid, e_rvalid, bram_en, busy, bram_we, bram_addr, bram_wdata,
             h_rdata, e_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b we=%h a=%h d=%h busy=%b exp=all zero",
                     bram_en, bram_we, bram_addr, bram_wdata, busy);
        end
        ARESET = 1'b0;
        idle(2);
    endtask

    task automatic test_engine_burst();
        int ac[8];
        for (int i = 0; i < 8; i++) begin
            eng_op(1'b0, AW'(i), '0, '0, ac[i]);
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL burst_busy i=%0d got=%b exp=1", i, busy);
            end
        end
        for (int i = 1; i < 8; i++) begin
            checks++;
            if (ac[i] != ac[0] + i) begin
                errors++;
                $display("FAIL burst_ack_cycle i=%0d got=%0d exp=%0d", i, ac[i], ac[0] + i);
            end
        end
        idle(5);
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL burst_drain got busy=%b pending=%0d exp busy=0 pending=0", busy, exp_q.size());
        end
    endtask

    task automatic test_host_write();
        int start, ac;
        start = cyc;
        host_op(1'b1, 10'h004, 32'h0000_0002, 4'hF, ac);
        checks++;
        if (ac != start) begin
            errors++;
            $display("FAIL hw_ack_cycle got=%0d exp=%0d", ac, start);
        end
        checks++;
        if ({bram_en, bram_we, bram_addr, bram_wdata} !== {1'b1, 4'hF, 10'h004, 32'h0000_0002}) begin
            errors++;
            $display("FAIL hw_bram got en=%b we=%h a=%h d=%h exp en=1 we=f a=004 d=00000002",
                     bram_en, bram_we, bram_addr, bram_wdata);
        end
        host_op(1'b1, 10'h005, DW'($urandom_range(1, 1000)), 4'h0, ac);
        checks++;
        if (bram_en !== 1'b1 || bram_we !== 4'h0) begin
            errors++;
            $display("FAIL hw_zero_strobe got en=%b we=%h exp en=1 we=0", bram_en, bram_we);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checks++;
            if (h_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL hw_no_rvalid cyc=%0d got=%b exp=0", cyc, h_rvalid);
            end
        end
        idle(1);
    endtask

    task automatic test_host_read();
        int ac;
        host_op(1'b0, 10'h004, '0, '0, ac);
        wait_h_rvalid("hr_data", ac, 32'h0000_0002);
    endtask

    task automatic test_byte_merge();
        int ac;
        eng_op(1'b1, 10'h010, 32'hAABB_CCDD, 4'hF, ac);
        host_op(1'b1, 10'h010, 32'h0000_1122, 4'h3, ac);
        host_op(1'b0, 10'h010, '0, '0, ac);
        wait_h_rvalid("merge_data", ac, 32'hAABB_1122);
    endtask

    task automatic test_arbitration();
        int dh, de;
        grant_log.delete();
        log_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 6; i++) host_op(1'b0, AW'(32 + i), '0, '0, dh);
            end
            begin
                for (int i = 0; i < 24; i++) eng_op(1'b0, AW'(64 + i), '0, '0, de);
            end
        join
        log_on = 1'b0;
        checks++;
        if (grant_log.size() != 30) begin
            errors++;
            $display("FAIL arb_grant_count got=%0d exp=30", grant_log.size());
        end
        for (int i = 0; i < grant_log.size() && i < 30; i++) begin
            checks++;
            if (grant_log[i] != ((i % (MAXG + 1)) == MAXG)) begin
                errors++;
                $display("FAIL arb_sequence idx=%0d got host=%b exp host=%b",
                         i, grant_log[i], (i % (MAXG + 1)) == MAXG);
            end
        end
        idle(6);
    endtask

    task automatic test_reset_inflight();
        int ac, start;
        logic [AW-1:0] ra;
        logic [DW-1:0] rd;
        host_op(1'b0, 10'h004, '0, '0, ac);
        eng_op(1'b0, 10'h005, '0, '0, ac);
        #2;
        ARESET = 1'b1;
        #1;
        checks++;
        if ({h_ack, e_ack, h_rvalid, e_rvalid, bram_en, busy, bram_we, bram_addr, bram_wdata,
             h_rdata, e_rdata} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got en=%b we=%h a=%h busy=%b exp=all zero",
                     bram_en, bram_we, bram_addr, busy);
        end
        repeat (2) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            checks++;
            if (h_rvalid !== 1'b0 || e_rvalid !== 1'b0) begin
                errors++;
                $display("FAIL postreset_rvalid cyc=%0d got h=%b e=%b exp=0", cyc, h_rvalid, e_rvalid);
            end
        end
        idle(1);
        ra = AW'($urandom_range(256, 511));
        rd = DW'($urandom);
        start = cyc;
        host_op(1'b1, ra, rd, 4'hF, ac);
        checks++;
        if (ac != start) begin
            errors++;
            $display("FAIL postreset_ack got=%0d exp=%0d", ac, start);
        end
        host_op(1'b0, ra, '0, '0, ac);
        wait_h_rvalid("postreset_read", ac, rd);
        idle(4);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_engine_burst();
        test_host_write();
        test_host_read();
        test_byte_merge();
        test_arbitration();
        test_reset_inflight();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain got=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_access_arbiter.md
Name: bram_access_arbiter

Overview:
Shares the single port of the AXI-Lite-mapped BRAM between two requesters: the host path (port h, driven by the AXI-Lite-to-BRAM bridge) and the JPEG engine path (port e).
- Arbitrates per cycle with engine priority and a bounded host-starvation guarantee.
- Drives registered BRAM control signals.
- Routes pipelined read data back to the requester that issued the read, in order, with fixed latency.

Parameters:
ADDR_WIDTH, 10, BRAM word-address width
DATA_WIDTH, 32, data width; multiple of 8
RD_LATENCY, 2, BRAM read latency in cycles from bram_en edge to valid bram_rdata (legal 1..3)
MAX_GRANT, 4, max consecutive engine grants while host waits (legal 1..15)

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
h_req  in  1  host access request
h_we  in  1  host write (1) / read (0)
h_addr  in  ADDR_WIDTH  host word address
h_wdata  in  DATA_WIDTH  host write data
h_wstrb  in  DATA_WIDTH/8  host byte strobes
h_ack  out  1  host request accepted this cycle
h_rvalid  out  1  host read data valid
h_rdata  out  DATA_WIDTH  host read data
e_req, e_we, e_addr, e_wdata, e_wstrb  in  as host  engine request bundle
e_ack, e_rvalid, e_rdata  out  as host  engine response bundle
bram_en  out  1  BRAM enable
bram_we  out  DATA_WIDTH/8  BRAM byte write enables
bram_addr  out  ADDR_WIDTH  BRAM address
bram_wdata  out  DATA_WIDTH  BRAM write data
bram_rdata  in  DATA_WIDTH  BRAM read data
busy  out  1  reads in flight

Behaviour:
- Reset (async, ARESET=1):
  - All outputs 0.
  - Streak counter 0.
  - Read-tag pipeline cleared; in-flight reads are dropped and never produce rvalid.
- Request protocol:
  - Requester holds req and its bundle stable until ack.
  - ack is a one-cycle combinational pulse in the cycle the request wins; it depends only on req inputs and registered state.
  - Requester may change the bundle or drop req the cycle after ack.
- Throughput: one access per cycle, no bubbles; back-to-back acks to the same or alternating requesters are legal.
- Arbitration, evaluated every cycle:
  - Only one req high: that requester wins.
  - Both high, streak < MAX_GRANT: engine wins; streak increments (saturating at MAX_GRANT).
  - Both high, streak == MAX_GRANT: host wins; streak clears.
  - Streak clears on any host grant and on any cycle h_req=0.
  - Neither high: no grant; bram_en=0 next cycle.
- BRAM drive:
  - Winner's bundle is registered onto bram_* at the ack-cycle edge.
  - bram_en=1 for exactly one cycle.
  - bram_we = wstrb if we=1, else 0.
  - A write with wstrb=0 still asserts bram_en and is acked; it produces no rvalid.
- Read return:
  - A registered tag pipeline of depth RD_LATENCY carries {valid, owner} per read.
  - Owner's rvalid pulses exactly RD_LATENCY+1 cycles after its ack cycle; rdata = bram_rdata in that cycle.
  - Non-owner rvalid stays 0; both rdata outputs may show bram_rdata.
  - Order is preserved.
  - Write-then-read to the same address returns the new data (BRAM port ordering; no bypass logic).
- busy = OR of tag-pipeline valid bits.
- No state machine beyond the streak counter and tag pipeline. All widths are fixed; no arithmetic beyond the counter.

Test Plan:
1. Host write: h_req, h_we=1, h_addr=0x004, h_wdata=0x00000002, h_wstrb=0xF, e_req=0 -> h_ack in cycle 0; cycle 1 has bram_en=1, bram_we=0xF, bram_addr=0x004, bram_wdata=0x2; no h_rvalid.
2. Host read of 0x004 after test 1, RD_LATENCY=2 -> h_rvalid exactly 3 cycles after h_ack, h_rdata=0x00000002; e_rvalid=0 throughout.
3. Both requesters reading continuously, MAX_GRANT=4 -> grant sequence E,E,E,E,H repeating for ≥20 cycles; each rvalid goes to the correct owner with the data of its address.
4. Engine reads of 0x000..0x007 on consecutive cycles, BRAM preloaded with value=address+1 -> 8 consecutive e_acks; e_rvalid high for 8 consecutive cycles; rdata 1..8 in order; busy high throughout.
5. Engine write 0x010=0xAABBCCDD with wstrb=0xF, then host write 0x010=0x00001122 with wstrb=0x3, then host read 0x010 -> h_rdata=0xAABB1122.
6. Two reads in flight, then ARESET pulsed mid-cycle -> all outputs go 0 immediately; no rvalid after reset release; next request is acked normally.
